// File: rtl/uart_rx_matrix_loader_pkg.sv
// Shared constants and state encodings for the UART matrix loader.
package uart_rx_matrix_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
  localparam int         CLKS_PER_BIT_DEF = 1250;
  localparam int         N_ELEM_DEF       = 4;
  localparam int         FRAME_LEN        = 2 * N_ELEM_DEF + 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_t;
  typedef enum logic [1:0] {F_SYNC, F_PAYLOAD, F_CHK} frame_state_t;

endpackage

// File: rtl/uart_rx_matrix_loader_if.sv
// Matrix handshake bundle: loader is master, consumer is slave.
interface uart_rx_matrix_loader_if #(parameter int WIDTH = 32) ();

  logic [WIDTH-1:0] act_flat;
  logic [WIDTH-1:0] wgt_flat;
  logic             matrix_valid;
  logic             matrix_ack;

  modport master (output act_flat, output wgt_flat, output matrix_valid, input matrix_ack);
  modport slave  (input act_flat, input wgt_flat, input matrix_valid, output matrix_ack);

endinterface

// File: rtl/uart_rx_matrix_loader_rx.sv
// UART 8N1 receiver: 2-flop synchronizer plus bit-level FSM.
//   state   | meaning
//   S_IDLE  | line idle, waiting for a falling edge
//   S_START | counting to the middle of the start bit
//   S_DATA  | sampling 8 data bits LSB first at mid-bit
//   S_STOP  | sampling the stop bit
module uart_rx_8n1
  import uart_rx_matrix_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err_frame,
  output logic       o_idle
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic          r_sync1, r_sync2, w_rx;
  bit_state_t    r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic [7:0]    r_byte, w_byte_n;
  logic          r_byte_valid, w_byte_valid_n;
  logic          r_err_frame, w_err_frame_n;

  assign w_rx         = r_sync2;
  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_err_frame  = r_err_frame;
  assign o_idle       = (r_state == S_IDLE);

  // Bring the asynchronous line into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Bit FSM state, counters and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_err_frame  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_bit        <= w_bit_n;
      r_shift      <= w_shift_n;
      r_byte       <= w_byte_n;
      r_byte_valid <= w_byte_valid_n;
      r_err_frame  <= w_err_frame_n;
    end
  end

  // Next-state logic: down-counter expiry marks each mid-bit sample point.
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_bit_n        = r_bit;
    w_shift_n      = r_shift;
    w_byte_n       = r_byte;
    w_byte_valid_n = 1'b0;
    w_err_frame_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_state_n = S_START;
          w_cnt_n   = CW'(CLKS_PER_BIT / 2);
        end
      end
      S_START: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - 1'b1;
        end else if (w_rx) begin
          w_state_n = S_IDLE;
        end else begin
          w_state_n = S_DATA;
          w_bit_n   = '0;
          w_cnt_n   = CW'(CLKS_PER_BIT - 1);
        end
      end
      S_DATA: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - 1'b1;
        end else begin
          w_shift_n = {w_rx, r_shift[7:1]};
          w_cnt_n   = CW'(CLKS_PER_BIT - 1);
          if (r_bit == 3'd7) w_state_n = S_STOP;
          else               w_bit_n   = r_bit + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - 1'b1;
        end else begin
          w_state_n = S_IDLE;
          if (w_rx) begin
            w_byte_n       = r_shift;
            w_byte_valid_n = 1'b1;
          end else begin
            w_err_frame_n = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_matrix_loader.sv
// Frame parser on top of the UART receiver: SYNC, N activations, N weights, XOR checksum.
//   state     | meaning
//   F_SYNC    | hunting for the sync byte
//   F_PAYLOAD | collecting activation then weight bytes into shadows
//   F_CHK     | waiting for the checksum byte, then publish or flag
module uart_rx_matrix_loader
  import uart_rx_matrix_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int         DATA_WIDTH   = 8,
  parameter int         N_ELEM       = N_ELEM_DEF,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_uartrx,
  uart_rx_matrix_loader_if.master m_if,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_valid,
  output logic       o_err_frame,
  output logic       o_err_chk,
  output logic       o_err_overrun
);

  localparam int VW     = N_ELEM * DATA_WIDTH;
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC);
  localparam int IW     = $clog2(2 * N_ELEM);
  localparam logic [TW-1:0] TO_LOAD = TW'(TO_CYC - 1);

  logic [7:0]    w_byte;
  logic          w_bv, w_ferr, w_idle, w_timeout, w_load;
  frame_state_t  r_fstate, w_fstate_n;
  logic [IW-1:0] r_idx, w_idx_n;
  logic [7:0]    r_xor, w_xor_n;
  logic [VW-1:0] r_act_sh, w_act_sh_n, r_wgt_sh, w_wgt_sh_n;
  logic [VW-1:0] r_act, w_act_n, r_wgt, w_wgt_n;
  logic          r_valid, w_valid_n;
  logic          r_err_chk, w_err_chk_n, r_err_ovr, w_err_ovr_n;
  logic [TW-1:0] r_to_cnt, w_to_n;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_uartrx),
    .o_byte      (w_byte),
    .o_byte_valid(w_bv),
    .o_err_frame (w_ferr),
    .o_idle      (w_idle)
  );

  assign o_rx_byte         = w_byte;
  assign o_rx_byte_valid   = w_bv;
  assign o_err_frame       = w_ferr;
  assign o_err_chk         = r_err_chk;
  assign o_err_overrun     = r_err_ovr;
  assign m_if.act_flat     = r_act;
  assign m_if.wgt_flat     = r_wgt;
  assign m_if.matrix_valid = r_valid;

  // Timeout only matters mid-frame while the receiver sits idle.
  assign w_timeout = (r_fstate != F_SYNC) && w_idle && (r_to_cnt == '0);

  // Frame FSM, shadows, published vectors and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fstate  <= F_SYNC;
      r_idx     <= '0;
      r_xor     <= '0;
      r_act_sh  <= '0;
      r_wgt_sh  <= '0;
      r_act     <= '0;
      r_wgt     <= '0;
      r_valid   <= 1'b0;
      r_err_chk <= 1'b0;
      r_err_ovr <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_fstate  <= w_fstate_n;
      r_idx     <= w_idx_n;
      r_xor     <= w_xor_n;
      r_act_sh  <= w_act_sh_n;
      r_wgt_sh  <= w_wgt_sh_n;
      r_act     <= w_act_n;
      r_wgt     <= w_wgt_n;
      r_valid   <= w_valid_n;
      r_err_chk <= w_err_chk_n;
      r_err_ovr <= w_err_ovr_n;
      r_to_cnt  <= w_to_n;
    end
  end

  // Frame parsing, timeout down-counter and valid/ack handshake.
  always_comb begin
    w_fstate_n  = r_fstate;
    w_idx_n     = r_idx;
    w_xor_n     = r_xor;
    w_act_sh_n  = r_act_sh;
    w_wgt_sh_n  = r_wgt_sh;
    w_act_n     = r_act;
    w_wgt_n     = r_wgt;
    w_valid_n   = r_valid;
    w_err_chk_n = 1'b0;
    w_err_ovr_n = 1'b0;
    w_load      = 1'b0;
    w_to_n      = r_to_cnt;

    if (r_fstate == F_SYNC || !w_idle) w_to_n = TO_LOAD;
    else if (r_to_cnt != '0)           w_to_n = r_to_cnt - 1'b1;

    case (r_fstate)
      F_SYNC: begin
        if (w_bv && w_byte == SYNC_BYTE) begin
          w_fstate_n = F_PAYLOAD;
          w_idx_n    = '0;
          w_xor_n    = '0;
        end
      end
      F_PAYLOAD: begin
        if (w_ferr || w_timeout) begin
          w_fstate_n = F_SYNC;
        end else if (w_bv) begin
          w_xor_n = r_xor ^ w_byte;
          for (int i = 0; i < N_ELEM; i++) begin
            if (r_idx == IW'(i))          w_act_sh_n[i*DATA_WIDTH +: DATA_WIDTH] = w_byte;
            if (r_idx == IW'(i + N_ELEM)) w_wgt_sh_n[i*DATA_WIDTH +: DATA_WIDTH] = w_byte;
          end
          if (r_idx == IW'(2 * N_ELEM - 1)) w_fstate_n = F_CHK;
          else                              w_idx_n    = r_idx + 1'b1;
        end
      end
      F_CHK: begin
        if (w_ferr || w_timeout) begin
          w_fstate_n = F_SYNC;
        end else if (w_bv) begin
          w_fstate_n = F_SYNC;
          if (w_byte != r_xor)                   w_err_chk_n = 1'b1;
          else if (!r_valid || m_if.matrix_ack)  w_load      = 1'b1;
          else                                   w_err_ovr_n = 1'b1;
        end
      end
      default: w_fstate_n = F_SYNC;
    endcase

    // A load in the same cycle as an ack wins, so valid stays high with new data.
    if (w_load) begin
      w_act_n   = r_act_sh;
      w_wgt_n   = r_wgt_sh;
      w_valid_n = 1'b1;
    end else if (r_valid && m_if.matrix_ack) begin
      w_valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_matrix_loader.sv
// Directed bench with a byte-level frame model checked every cycle.
module tb_uart_rx_matrix_loader;
  import uart_rx_matrix_loader_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         gap;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uartrx = 1'b1;
  logic [7:0] rx_byte;
  logic       rbv, err_frame, err_chk, err_ovr;

  int errors = 0;
  int checks = 0;
  int n_chk = 0, n_ovr = 0, n_frm = 0, n_rbv = 0;

  ent_t       q[$];
  ent_t       e;
  logic [7:0] pl[$];
  logic [31:0] e_act = '0, e_wgt = '0;
  bit         e_valid = 0, e_chk = 0, e_ovr = 0, in_frame = 0;
  bit         nxt_chk, nxt_ovr, loaded;
  logic [7:0] x;
  logic [31:0] ld_act, ld_wgt;

  logic [7:0] FR1  [FRAME_LEN] = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h05, 8'h01, 8'h00, 8'h00, 8'h01, 8'h02};
  logic [7:0] FRBC [FRAME_LEN] = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h05, 8'h01, 8'h00, 8'h00, 8'h01, 8'h03};
  logic [7:0] FR2  [FRAME_LEN] = '{8'hA5, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h00};
  logic [7:0] FR3  [FRAME_LEN] = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h80};

  uart_rx_matrix_loader_if #(.WIDTH(32)) mif ();

  uart_rx_matrix_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_uartrx       (uartrx),
    .m_if           (mif),
    .o_rx_byte      (rx_byte),
    .o_rx_byte_valid(rbv),
    .o_err_frame    (err_frame),
    .o_err_chk      (err_chk),
    .o_err_overrun  (err_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drive_bit(input logic v);
    uartrx = v;
    cycles(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad, input bit gap);
    q.push_back('{b: b, bad: bad, gap: gap});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(!bad);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] f [FRAME_LEN], input bit gap);
    for (int i = 0; i < FRAME_LEN; i++) send_byte(f[i], 1'b0, gap && (i == 0));
  endtask

  task automatic pulse_ack();
    mif.matrix_ack = 1'b1;
    cycles(1);
    mif.matrix_ack = 1'b0;
    cycles(2);
  endtask

  // Byte-level model: consume each received byte in arrival order.
  task automatic model_byte(input logic [7:0] b);
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1;
        pl.delete();
      end
    end else if (pl.size() < 8) begin
      pl.push_back(b);
    end else begin
      in_frame = 0;
      x = 8'h00;
      foreach (pl[i]) x ^= pl[i];
      if (x != b) begin
        nxt_chk = 1;
      end else if (!e_valid || mif.matrix_ack) begin
        loaded = 1;
        ld_act = {pl[3], pl[2], pl[1], pl[0]};
        ld_wgt = {pl[7], pl[6], pl[5], pl[4]};
      end else begin
        nxt_ovr = 1;
      end
    end
  endtask

  // Per-cycle comparison after each edge; model advances before the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("matrix_valid", mif.matrix_valid, e_valid);
      check("act_flat", mif.act_flat, e_act);
      check("wgt_flat", mif.wgt_flat, e_wgt);
      check("err_chk", err_chk, e_chk);
      check("err_overrun", err_ovr, e_ovr);
      if (err_chk)   n_chk++;
      if (err_ovr)   n_ovr++;
      if (err_frame) n_frm++;
      if (rbv)       n_rbv++;
      @(negedge clk);
      nxt_chk = 0;
      nxt_ovr = 0;
      loaded  = 0;
      if (!rst_n) begin
        e_act = '0; e_wgt = '0; e_valid = 0; in_frame = 0;
        pl.delete();
        q.delete();
      end else begin
        if (rbv || err_frame) begin
          check("byte_expected", 32'(q.size() == 0), 32'd0);
          if (q.size() != 0) begin
            e = q.pop_front();
            if (e.gap) in_frame = 0;
            if (rbv) begin
              check("rx_byte", {23'd0, e.bad, e.b}, {24'd0, rx_byte});
              model_byte(e.b);
            end else begin
              check("err_frame_on_bad_stop", 32'(e.bad), 32'd1);
              in_frame = 0;
            end
          end
        end
        if (loaded) begin
          e_valid = 1;
          e_act   = ld_act;
          e_wgt   = ld_wgt;
        end else if (e_valid && mif.matrix_ack) begin
          e_valid = 0;
        end
      end
      e_chk = nxt_chk;
      e_ovr = nxt_ovr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.matrix_ack = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    cycles(3);
    check("reset_valid", mif.matrix_valid, 0);
    check("reset_act", mif.act_flat, 32'h0);
    check("reset_wgt", mif.wgt_flat, 32'h0);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_pulses", {rbv, err_frame, err_chk, err_ovr}, 4'b0000);
    rst_n = 1'b1;
    cycles(5);

    // Short low glitch on an idle line.
    uartrx = 1'b0;
    cycles(3);
    uartrx = 1'b1;
    cycles(40);
    check("glitch_no_byte", n_rbv, 0);

    // Bad checksum with nothing loaded yet.
    send_frame(FRBC, 1'b0);
    check("badchk_pulses", n_chk, 1);
    check("badchk_valid", mif.matrix_valid, 0);
    check("badchk_act", mif.act_flat, 32'h0);

    // Good frame.
    send_frame(FR1, 1'b0);
    check("good_act", mif.act_flat, 32'h05040201);
    check("good_wgt", mif.wgt_flat, 32'h01000001);
    check("good_valid", mif.matrix_valid, 1);
    check("good_no_err", n_chk + n_ovr + n_frm, 1);
    pulse_ack();
    check("ack_drops_valid", mif.matrix_valid, 0);

    // Garbage, then a load, then an overrun.
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_frame(FR1, 1'b0);
    check("garbage_then_load", mif.act_flat, 32'h05040201);
    send_frame(FR2, 1'b0);
    check("overrun_pulse", n_ovr, 1);
    check("overrun_keeps_act", mif.act_flat, 32'h05040201);
    pulse_ack();
    check("ack_valid_low", mif.matrix_valid, 0);
    send_frame(FR2, 1'b0);
    check("reload_act", mif.act_flat, 32'h11111111);
    check("reload_valid", mif.matrix_valid, 1);
    pulse_ack();

    // Framing error on a2 aborts the frame.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    check("frame_err_pulse", n_frm, 1);
    check("aborted_not_loaded", mif.matrix_valid, 0);
    send_frame(FR3, 1'b0);
    check("after_abort_act", mif.act_flat, 32'h40302010);
    check("after_abort_wgt", mif.wgt_flat, 32'h80706050);
    pulse_ack();

    // Partial frame dropped by inter-byte timeout.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    cycles(21 * CPB);
    send_frame(FR1, 1'b1);
    check("timeout_then_load", mif.act_flat, 32'h05040201);
    check("timeout_valid", mif.matrix_valid, 1);
    check("timeout_no_chk", n_chk, 1);

    // Reset in the middle of a payload byte.
    send_byte(8'hA5, 1'b0, 1'b0);
    uartrx = 1'b0;
    cycles(CPB);
    uartrx = 1'b1;
    cycles(CPB);
    uartrx = 1'b0;
    cycles(CPB + CPB / 2);
    rst_n = 1'b0;
    cycles(1);
    check("midrst_valid", mif.matrix_valid, 0);
    check("midrst_act", mif.act_flat, 32'h0);
    check("midrst_rx_byte", rx_byte, 8'h00);
    uartrx = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(4 * CPB);
    send_frame(FR2, 1'b0);
    check("post_reset_act", mif.act_flat, 32'h11111111);
    check("post_reset_valid", mif.matrix_valid, 1);

    cycles(4);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
